// File: rtl/bcd_entry_pkg.sv
// Shared constants and state type for the keypad BCD operand entry block.
// Imported by the interface, the converter and the top-level module.
package bcd_entry_pkg;

    localparam logic [3:0] KEY_MINUS = 4'd10;
    localparam logic [3:0] KEY_BKSP  = 4'd11;
    localparam logic [3:0] KEY_CLR   = 4'd12;
    localparam logic [3:0] KEY_ENTER = 4'd13;

    localparam logic [3:0] SIGN_POS = 4'd0;
    localparam logic [3:0] SIGN_NEG = 4'd10;

    localparam logic [1:0] MAX_DIGITS = 2'd3;

    typedef enum logic [1:0] {
        EMPTY,
        ENTRY,
        LOCKED
    } state_t;

endpackage

// File: rtl/bcd_entry_if.sv
// Key-input and operand-output signals of bcd_entry bundled as one interface.
// The num_bin signal exists only when BCD_ENTRY_BIN_EN is defined.
interface bcd_entry_if;

    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_ready;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  sign;
    logic [11:0] num;
    logic [1:0]  digit_cnt;
    logic        err;
`ifdef BCD_ENTRY_BIN_EN
    logic [9:0]  num_bin;
`endif

    // master is the entry block itself; slave is the keypad/consumer side
    modport master (
        input  key_valid, key_code, out_ready,
`ifdef BCD_ENTRY_BIN_EN
        output num_bin,
`endif
        output key_ready, out_valid, sign, num, digit_cnt, err
    );

    modport slave (
        output key_valid, key_code, out_ready,
`ifdef BCD_ENTRY_BIN_EN
        input  num_bin,
`endif
        input  key_ready, out_valid, sign, num, digit_cnt, err
    );

endinterface

// File: rtl/bcd_entry_bcd3_to_bin.sv
// Combinational 3-digit BCD to 10-bit binary converter using shift-add only.
module bcd3_to_bin (
    input  logic [11:0] bcd,
    output logic [9:0]  bin
);

    logic [9:0] n1;
    logic [9:0] n2;
    logic [9:0] n3;

    assign n1 = {6'd0, bcd[11:8]};
    assign n2 = {6'd0, bcd[7:4]};
    assign n3 = {6'd0, bcd[3:0]};

    // x100 = x64 + x32 + x4, x10 = x8 + x2; max 999 fits 10 bits
    assign bin = (n1 << 6) + (n1 << 5) + (n1 << 2) + (n2 << 3) + (n2 << 1) + n3;

endmodule

// File: rtl/bcd_entry.sv
// Keypad-side producer of signed 3-digit BCD operands with valid/ready output.
// Optional registered binary output num_bin enabled by defining BCD_ENTRY_BIN_EN.
module bcd_entry
    import bcd_entry_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    bcd_entry_if.master bus
);

    state_t      state_q, state_d;
    logic [3:0]  sign_q, sign_d;
    logic [11:0] num_q, num_d;
    logic [1:0]  digit_cnt_q, digit_cnt_d;
    logic        err_q, err_d;
    logic        key_accept;

    assign key_accept = bus.key_valid && (state_q != LOCKED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            sign_q      <= SIGN_POS;
            num_q       <= 12'h000;
            digit_cnt_q <= 2'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            num_q       <= num_d;
            digit_cnt_q <= digit_cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        num_d       = num_q;
        digit_cnt_d = digit_cnt_q;
        err_d       = 1'b0;

        if (state_q == LOCKED) begin
            if (bus.out_ready) begin
                state_d     = EMPTY;
                sign_d      = SIGN_POS;
                num_d       = 12'h000;
                digit_cnt_d = 2'd0;
            end
        end else if (key_accept) begin
            if (bus.key_code <= 4'd9) begin
                if (digit_cnt_q < MAX_DIGITS) begin
                    num_d       = {num_q[7:0], bus.key_code};
                    digit_cnt_d = digit_cnt_q + 2'd1;
                    state_d     = ENTRY;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                case (bus.key_code)
                    KEY_MINUS: sign_d = (sign_q == SIGN_NEG) ? SIGN_POS : SIGN_NEG;
                    KEY_BKSP: begin
                        if (digit_cnt_q != 2'd0) begin
                            num_d       = {4'h0, num_q[11:4]};
                            digit_cnt_d = digit_cnt_q - 2'd1;
                            if (digit_cnt_q == 2'd1) begin
                                state_d = EMPTY;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    KEY_CLR: begin
                        num_d       = 12'h000;
                        sign_d      = SIGN_POS;
                        digit_cnt_d = 2'd0;
                        state_d     = EMPTY;
                    end
                    KEY_ENTER: begin
                        state_d = LOCKED;
                        // a committed zero is always positive
                        if (num_q == 12'h000) begin
                            sign_d = SIGN_POS;
                        end
                    end
                    default: err_d = 1'b1;
                endcase
            end
        end
    end

    assign bus.key_ready = (state_q != LOCKED);
    assign bus.out_valid = (state_q == LOCKED);
    assign bus.sign      = sign_q;
    assign bus.num       = num_q;
    assign bus.digit_cnt = digit_cnt_q;
    assign bus.err       = err_q;

`ifdef BCD_ENTRY_BIN_EN
    logic [9:0] num_bin_q, num_bin_d;

    bcd3_to_bin u_bcd3_to_bin (
        .bcd (num_q),
        .bin (num_bin_d)
    );

    // ENTER never changes num, so this one-cycle lag is settled by the first out_valid cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_bin_q <= 10'd0;
        end else begin
            num_bin_q <= num_bin_d;
        end
    end

    assign bus.num_bin = num_bin_q;
`endif

endmodule

// File: tb/tb_bcd_entry.sv
// Testbench for bcd_entry: a directed vector table followed by randomized keys against a reference model.
// Also covers the num_bin output when BCD_ENTRY_BIN_EN is defined.
module tb_bcd_entry;
    import bcd_entry_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    bcd_entry_if bus ();

    bcd_entry dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        kv;
        logic [3:0]  kc;
        logic        ordy;
        logic [11:0] num;
        logic [3:0]  sign;
        logic [1:0]  cnt;
        logic        err;
        logic        ov;
        logic        kr;
    } vec_t;

    vec_t vecs[$];

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: digits as a list of decimal values, most significant first
    int mDigits[$];
    bit mNeg;
    bit mLocked;
    bit mErr;
    int mBin;

    function automatic int decVal();
        int v = 0;
        foreach (mDigits[i]) v = v * 10 + mDigits[i];
        return v;
    endfunction

    function automatic int bcdVal();
        int v = 0;
        foreach (mDigits[i]) v = v * 16 + mDigits[i];
        return v;
    endfunction

    task automatic modelClear();
        mDigits.delete();
        mNeg = 1'b0;
    endtask

    task automatic modelStep(input logic r, input logic kv, input logic [3:0] kc, input logic ordy);
        int prevDec = decVal();
        mErr = 1'b0;
        if (!r) begin
            modelClear();
            mLocked = 1'b0;
            mBin    = 0;
        end else begin
            mBin = prevDec;
            if (mLocked) begin
                if (ordy) begin
                    modelClear();
                    mLocked = 1'b0;
                end
            end else if (kv) begin
                if (kc <= 4'd9) begin
                    if (mDigits.size() < 3) mDigits.push_back(int'(kc));
                    else mErr = 1'b1;
                end else if (kc == 4'd10) begin
                    mNeg = !mNeg;
                end else if (kc == 4'd11) begin
                    if (mDigits.size() > 0) void'(mDigits.pop_back());
                    else mErr = 1'b1;
                end else if (kc == 4'd12) begin
                    modelClear();
                end else if (kc == 4'd13) begin
                    mLocked = 1'b1;
                    if (prevDec == 0) mNeg = 1'b0;
                end else begin
                    mErr = 1'b1;
                end
            end
        end
    endtask

    task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic kv, input logic [3:0] kc, input logic ordy);
        rst_n         = r;
        bus.key_valid = kv;
        bus.key_code  = kc;
        bus.out_ready = ordy;
        modelStep(r, kv, kc, ordy);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkField({tag, " num"}, 16'(bus.num), 16'(bcdVal()));
        checkField({tag, " sign"}, 16'(bus.sign), mNeg ? 16'd10 : 16'd0);
        checkField({tag, " digit_cnt"}, 16'(bus.digit_cnt), 16'(mDigits.size()));
        checkField({tag, " err"}, 16'(bus.err), 16'(mErr));
        checkField({tag, " out_valid"}, 16'(bus.out_valid), 16'(mLocked));
        checkField({tag, " key_ready"}, 16'(bus.key_ready), 16'(!mLocked));
`ifdef BCD_ENTRY_BIN_EN
        checkField({tag, " num_bin"}, 16'(bus.num_bin), 16'(mBin));
`endif
    endtask

    task automatic addVec(input logic r, input logic kv, input logic [3:0] kc, input logic ordy,
                          input logic [11:0] num, input logic [3:0] sign, input logic [1:0] cnt,
                          input logic err, input logic ov, input logic kr);
        vec_t v;
        v.rst_n = r;   v.kv = kv;     v.kc = kc;   v.ordy = ordy;
        v.num   = num; v.sign = sign; v.cnt = cnt; v.err = err; v.ov = ov; v.kr = kr;
        vecs.push_back(v);
    endtask

    initial begin
        logic [11:0] lockedNum;
        mLocked = 1'b0;
        mBin    = 0;
        modelClear();
        rst_n         = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.out_ready = 1'b0;

        //      rst kv code  ordy  num     sign  cnt err ov kr
        addVec(1, 1, 4'd1,  0, 12'h001, 4'd0,  1, 0, 0, 1);
        addVec(1, 1, 4'd2,  0, 12'h012, 4'd0,  2, 0, 0, 1);
        addVec(1, 1, 4'd3,  0, 12'h123, 4'd0,  3, 0, 0, 1);
        addVec(1, 1, 4'd13, 0, 12'h123, 4'd0,  3, 0, 1, 0);
        addVec(1, 0, 4'd0,  0, 12'h123, 4'd0,  3, 0, 1, 0);
        addVec(1, 1, 4'd12, 0, 12'h123, 4'd0,  3, 0, 1, 0);
        addVec(1, 0, 4'd0,  1, 12'h000, 4'd0,  0, 0, 0, 1);
        addVec(1, 1, 4'd4,  0, 12'h004, 4'd0,  1, 0, 0, 1);
        addVec(1, 1, 4'd10, 0, 12'h004, 4'd10, 1, 0, 0, 1);
        addVec(1, 1, 4'd5,  0, 12'h045, 4'd10, 2, 0, 0, 1);
        addVec(1, 1, 4'd6,  0, 12'h456, 4'd10, 3, 0, 0, 1);
        addVec(1, 1, 4'd7,  0, 12'h456, 4'd10, 3, 1, 0, 1);
        addVec(1, 0, 4'd0,  0, 12'h456, 4'd10, 3, 0, 0, 1);
        addVec(1, 1, 4'd12, 0, 12'h000, 4'd0,  0, 0, 0, 1);
        addVec(1, 1, 4'd9,  0, 12'h009, 4'd0,  1, 0, 0, 1);
        addVec(1, 1, 4'd8,  0, 12'h098, 4'd0,  2, 0, 0, 1);
        addVec(1, 1, 4'd11, 0, 12'h009, 4'd0,  1, 0, 0, 1);
        addVec(1, 1, 4'd11, 0, 12'h000, 4'd0,  0, 0, 0, 1);
        addVec(1, 1, 4'd11, 0, 12'h000, 4'd0,  0, 1, 0, 1);
        addVec(1, 1, 4'd10, 0, 12'h000, 4'd10, 0, 0, 0, 1);
        addVec(1, 1, 4'd0,  0, 12'h000, 4'd10, 1, 0, 0, 1);
        addVec(1, 1, 4'd0,  0, 12'h000, 4'd10, 2, 0, 0, 1);
        addVec(1, 1, 4'd13, 0, 12'h000, 4'd0,  2, 0, 1, 0);
        addVec(1, 0, 4'd0,  1, 12'h000, 4'd0,  0, 0, 0, 1);
        addVec(1, 1, 4'd15, 0, 12'h000, 4'd0,  0, 1, 0, 1);
        addVec(1, 0, 4'd0,  0, 12'h000, 4'd0,  0, 0, 0, 1);
        addVec(1, 1, 4'd5,  1, 12'h005, 4'd0,  1, 0, 0, 1);
        addVec(1, 1, 4'd13, 1, 12'h005, 4'd0,  1, 0, 1, 0);
        addVec(1, 0, 4'd0,  1, 12'h000, 4'd0,  0, 0, 0, 1);
        addVec(1, 1, 4'd7,  0, 12'h007, 4'd0,  1, 0, 0, 1);
        addVec(1, 1, 4'd10, 0, 12'h007, 4'd10, 1, 0, 0, 1);
        addVec(1, 1, 4'd1,  0, 12'h071, 4'd10, 2, 0, 0, 1);
        addVec(0, 1, 4'd5,  0, 12'h000, 4'd0,  0, 0, 0, 1);
        addVec(1, 1, 4'd3,  0, 12'h003, 4'd0,  1, 0, 0, 1);
        addVec(1, 1, 4'd13, 0, 12'h003, 4'd0,  1, 0, 1, 0);
        addVec(0, 0, 4'd0,  0, 12'h000, 4'd0,  0, 0, 0, 1);

        applyStimulus(0, 0, 4'd0, 0);
        applyStimulus(0, 0, 4'd0, 0);
        checkField("reset num", 16'(bus.num), 16'h0);
        checkField("reset sign", 16'(bus.sign), 16'd0);
        checkField("reset digit_cnt", 16'(bus.digit_cnt), 16'd0);
        checkField("reset err", 16'(bus.err), 16'd0);
        checkField("reset out_valid", 16'(bus.out_valid), 16'd0);
        checkField("reset key_ready", 16'(bus.key_ready), 16'd1);
`ifdef BCD_ENTRY_BIN_EN
        checkField("reset num_bin", 16'(bus.num_bin), 16'd0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].kv, vecs[i].kc, vecs[i].ordy);
            checkField($sformatf("vec%0d num", i), 16'(bus.num), 16'(vecs[i].num));
            checkField($sformatf("vec%0d sign", i), 16'(bus.sign), 16'(vecs[i].sign));
            checkField($sformatf("vec%0d digit_cnt", i), 16'(bus.digit_cnt), 16'(vecs[i].cnt));
            checkField($sformatf("vec%0d err", i), 16'(bus.err), 16'(vecs[i].err));
            checkField($sformatf("vec%0d out_valid", i), 16'(bus.out_valid), 16'(vecs[i].ov));
            checkField($sformatf("vec%0d key_ready", i), 16'(bus.key_ready), 16'(vecs[i].kr));
`ifdef BCD_ENTRY_BIN_EN
            if (vecs[i].ov) begin
                checkField($sformatf("vec%0d num_bin", i), 16'(bus.num_bin),
                           16'(100 * vecs[i].num[11:8] + 10 * vecs[i].num[7:4] + vecs[i].num[3:0]));
            end
`endif
        end

        // Held LOCKED with every key type hammering: operand must not move and no err
        applyStimulus(1, 1, 4'd8, 0);
        applyStimulus(1, 1, 4'd4, 0);
        applyStimulus(1, 1, 4'd13, 0);
        lockedNum = bus.num;
        for (int k = 10; k < 16; k++) begin
            applyStimulus(1, 1, 4'(k), 0);
            checkOutput($sformatf("locked key%0d", k));
            checkField("locked num stable", 16'(bus.num), 16'h084);
        end
        checkField("locked num held", 16'(lockedNum), 16'h084);
        applyStimulus(1, 1, 4'd2, 1);
        checkOutput("handshake");
        applyStimulus(1, 1, 4'd2, 0);
        checkOutput("first key after handshake");

        for (int n = 0; n < 800; n++) begin
            applyStimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0),
                          4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            checkOutput($sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/bcd_entry.md
# bcd_entry

Keypad-side producer of signed 3-digit BCD operands for the calculator datapath. Accepts one key code per handshake, shifts decimal digits in from the right, toggles a sign digit, supports backspace/clear, and on ENTER presents a stable `{sign, num}` operand through a valid/ready handshake. Its output is exactly the operand format the subtraction/addition datapath consumes: sign nibble 0 or 10, plus three BCD digits `{n1,n2,n3}`.

## Interface
- No parameters; digit count fixed at 3.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `key_valid`  in  1  key code presented.
- `key_code`  in  4  key code: 0–9 digit, 10 MINUS, 11 BACKSPACE, 12 CLEAR, 13 ENTER, 14–15 invalid.
- `key_ready`  out  1  block can accept a key; equals `state != LOCKED`.
- `out_valid`  out  1  committed operand available.
- `out_ready`  in  1  consumer takes the operand.
- `sign`  out  4  4'd0 means positive, 4'd10 means negative.
- `num`  out  12  BCD digits `{n1,n2,n3}`, with n3 the least significant.
- `digit_cnt`  out  2  number of digits entered (0–3).
- `err`  out  1  one-cycle pulse on a rejected key.
- `num_bin`  out  10  binary value of `num`; present only with `BCD_ENTRY_BIN_EN`.

## Operation
- A key is accepted on an edge where `key_valid && key_ready`. Keys presented while `key_ready` is low are ignored and produce no `err`.
- States:
  - EMPTY: `digit_cnt == 0`.
  - ENTRY: `digit_cnt` is 1–3.
  - LOCKED: operand committed, waiting for the consumer.
- Digit d when `digit_cnt < 3`:
  - `num <= {num[7:0], d}`, `digit_cnt++`, go to ENTRY.
  - Leading zeros count as digits: keys 0, 5 give `num = 0x005`, `digit_cnt = 2`.
- Digit when `digit_cnt == 3`: no change, `err` pulse.
- MINUS: `sign <= (sign == 10) ? 0 : 10`. Allowed in EMPTY and ENTRY. Digits are unchanged.
- BACKSPACE when `digit_cnt > 0`:
  - `num <= {4'h0, num[11:4]}`, `digit_cnt--`.
  - Go to EMPTY when the count reaches 0. Sign is retained.
- BACKSPACE when `digit_cnt == 0`: no change, `err` pulse.
- CLEAR: `num <= 0`, `sign <= 0`, `digit_cnt <= 0`, go to EMPTY. Never sets `err`.
- ENTER (from EMPTY or ENTRY): go to LOCKED.
  - If `num == 0` then `sign <= 0` (no negative zero).
  - ENTER on EMPTY commits 0.
- Key codes 14–15: no change, `err` pulse.
- LOCKED:
  - `out_valid = 1`; `sign`, `num` and `digit_cnt` are held stable.
  - On `out_valid && out_ready`: clear `num`, `sign` and `digit_cnt`, go to EMPTY.
- Digits are guaranteed BCD because only codes 0–9 are shifted in.

## Timing
- Reset values: state EMPTY, `sign = 0`, `num = 0`, `digit_cnt = 0`, `out_valid = 0`, `key_ready = 1`, `err = 0`, `num_bin = 0`.
- Register outputs update on the edge that accepts the key and are visible the next cycle.
- `err` is registered: high for exactly the cycle after the rejected key.
- `out_valid` rises the cycle after ENTER is accepted.
- `out_valid` falls, and `key_ready` rises, the cycle after the output handshake completes.
- Minimum turnaround is ENTER → LOCKED → (handshake) → EMPTY. A new key can be accepted the cycle after the handshake.
- `out_ready` may be held high: the operand is then visible for exactly one cycle.
- Keys can be accepted back-to-back, one per cycle, in EMPTY and ENTRY.
- A reset asserted mid-entry or in LOCKED returns every output to its reset value on that edge. A pending operand is discarded.

## Configuration
- `BCD_ENTRY_BIN_EN` defined:
  - Adds the `num_bin` output: `100*n1 + 10*n2 + n3`, registered.
  - `num_bin` lags `num` by one cycle; in LOCKED it is valid from the first `out_valid` cycle.
  - Maximum value is 999, which fits in 10 bits.
- `BCD_ENTRY_BIN_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `bcd_entry_pkg` holds:
  - key code constants: KEY_MINUS = 10, KEY_BKSP = 11, KEY_CLR = 12, KEY_ENTER = 13;
  - sign constants: SIGN_POS = 4'd0, SIGN_NEG = 4'd10;
  - the state enum {EMPTY, ENTRY, LOCKED}.
- One sub-module, `bcd3_to_bin`: a combinational 3-digit BCD to 10-bit binary converter using shift-add (×100 = <<6 + <<5 + <<2; ×10 = <<3 + <<1). Instantiated only under `BCD_ENTRY_BIN_EN`; output registered in `bcd_entry`.

## Test plan
- Reset, then keys 1, 2, 3, ENTER with `out_ready = 0` → `num = 0x123`, `sign = 0`, `out_valid = 1` held, `key_ready = 0`. Then `out_ready = 1` → next cycle `num = 0`, EMPTY. With macro: `num_bin = 123`.
- Keys 4, MINUS, 5, 6, 7 → `num = 0x456`, `sign = 10`; the fourth digit gives one `err` pulse and `num` is unchanged.
- Keys 9, 8, BACKSPACE, BACKSPACE, BACKSPACE → `num` goes 0x009, 0x098, 0x009, 0x000; the third BACKSPACE gives an `err` pulse; final `digit_cnt = 0`.
- MINUS, 0, 0, ENTER → committed `num = 0x000`, `sign = 0`. Key code 15 → `err` pulse, no state change.
- Keys 7, 1, reset low for one cycle, key 3 → `num = 0x003`, `digit_cnt = 1`, `sign = 0`.
- In LOCKED, `key_valid = 1` with CLEAR → ignored, no `err`, operand unchanged until the handshake.
